// File: rtl/ps2_keymap_decoder.sv
// PS/2 keyboard receiver and key-map decoder.
// Receives device-to-host PS/2 frames, validates start/parity/stop, aborts
// stalled frames, handles E0/F0 prefixes and maintains a per-key held bitmap
// against a parameter-programmable scan-code map.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   PS2C, PS2D   asynchronous PS/2 clock and data lines
//   key_state    bit i high while key i is held
//   key_press    one-cycle pulse when key_state[i] rises
//   key_release  one-cycle pulse when key_state[i] falls
//   code_valid   one-cycle pulse for every decoded non-prefix byte
//   code         scan code, qualified by code_valid
//   code_break   F0 prefix preceded code
//   code_ext     E0 prefix preceded code
//   frame_err    one-cycle pulse on parity, stop or timeout error
//
// Receiver states:
//   state    | meaning
//   S_IDLE   | waiting for a start bit (0)
//   S_DATA   | shifting 8 data bits, LSB first
//   S_PARITY | sampling the odd-parity bit
//   S_STOP   | sampling the stop bit, accepting or rejecting the byte
module ps2_keymap_decoder #(
    parameter int CLK_DIV     = 4,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000,
    parameter int NUM_KEYS    = 21,
    parameter logic [NUM_KEYS*8-1:0] KEYMAP = 168'h3A31322A21221A3B33342B231B1C3C352C2D241D15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                PS2C,
    input  logic                PS2D,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                code_valid,
    output logic [7:0]          code,
    output logic                code_break,
    output logic                code_ext,
    output logic                frame_err
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FW = $clog2(FILTER_LEN);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // Line index 0 = PS2C, 1 = PS2D throughout.
    logic [1:0]    sync_a, sync_b, filt;
    logic [FW-1:0] fcnt [2];
    logic          filt_c_d;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic          bit_evt, bit_val;

    state_t        state, state_nxt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_ok;
    logic [TW-1:0] to_cnt;
    logic          timeout, accept, frame_bad;
    logic          brk, ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 2'b11;
            sync_b <= 2'b11;
        end else begin
            sync_a <= {PS2D, PS2C};
            sync_b <= sync_a;
        end
    end

    assign tick = (div_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst)       div_cnt <= '0;
        else if (tick) div_cnt <= DW'(CLK_DIV - 1);
        else           div_cnt <= div_cnt - 1'b1;
    end

    // fcnt counts consecutive samples that disagree with the filtered level;
    // the FILTER_LEN-th disagreeing sample flips the level.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt    <= 2'b11;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else if (tick) begin
            for (int j = 0; j < 2; j++) begin
                if (sync_b[j] == filt[j]) begin
                    fcnt[j] <= '0;
                end else if (fcnt[j] == FW'(FILTER_LEN - 1)) begin
                    filt[j] <= sync_b[j];
                    fcnt[j] <= '0;
                end else begin
                    fcnt[j] <= fcnt[j] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) filt_c_d <= 1'b1;
        else     filt_c_d <= filt[0];
    end

    assign bit_evt = filt_c_d & ~filt[0];
    assign bit_val = filt[1];

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        frame_bad = 1'b0;
        timeout   = (state != S_IDLE) && !bit_evt && (to_cnt == '0);
        if (timeout) begin
            state_nxt = S_IDLE;
        end else if (bit_evt) begin
            case (state)
                S_IDLE:   if (!bit_val) state_nxt = S_DATA;
                S_DATA:   if (bit_cnt == 3'd7) state_nxt = S_PARITY;
                S_PARITY: state_nxt = S_STOP;
                S_STOP: begin
                    state_nxt = S_IDLE;
                    if (bit_val && par_ok) accept    = 1'b1;
                    else                   frame_bad = 1'b1;
                end
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            shreg   <= '0;
            par_ok  <= 1'b0;
        end else if (bit_evt) begin
            case (state)
                S_IDLE:   bit_cnt <= '0;
                S_DATA: begin
                    shreg   <= {bit_val, shreg[7:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                S_PARITY: par_ok <= ^{shreg, bit_val};
                default:  ;
            endcase
        end
    end

    // Reloaded on every bit event and while idle, so it only expires
    // TIMEOUT_CYC cycles after the last bit of an unfinished frame.
    always_ff @(posedge clk) begin
        if (rst)                              to_cnt <= '0;
        else if (bit_evt || state == S_IDLE)  to_cnt <= TW'(TIMEOUT_CYC - 1);
        else if (to_cnt != '0)                to_cnt <= to_cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_state   <= '0;
            key_press   <= '0;
            key_release <= '0;
            code_valid  <= 1'b0;
            code        <= '0;
            code_break  <= 1'b0;
            code_ext    <= 1'b0;
            frame_err   <= 1'b0;
            brk         <= 1'b0;
            ext         <= 1'b0;
        end else begin
            key_press   <= '0;
            key_release <= '0;
            code_valid  <= 1'b0;
            frame_err   <= 1'b0;
            if (timeout || frame_bad) begin
                frame_err <= 1'b1;
                brk       <= 1'b0;
                ext       <= 1'b0;
            end else if (accept) begin
                if (shreg == 8'hE0) begin
                    ext <= 1'b1;
                end else if (shreg == 8'hF0) begin
                    brk <= 1'b1;
                end else begin
                    code_valid <= 1'b1;
                    code       <= shreg;
                    code_break <= brk;
                    code_ext   <= ext;
                    brk        <= 1'b0;
                    ext        <= 1'b0;
                    if (shreg == 8'h00 || shreg == 8'hFF) begin
                        // Keyboard overrun: release everything at once.
                        key_state   <= '0;
                        key_release <= key_state;
                    end else if (!ext) begin
                        // Duplicate map entries all follow the same code.
                        for (int i = 0; i < NUM_KEYS; i++) begin
                            if (KEYMAP[8*i +: 8] == shreg) begin
                                if (brk) begin
                                    key_state[i]   <= 1'b0;
                                    key_release[i] <= key_state[i];
                                end else begin
                                    key_state[i] <= 1'b1;
                                    key_press[i] <= ~key_state[i];
                                end
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keymap_decoder.sv
`timescale 1ns/1ps
module tb_ps2_keymap_decoder;

    localparam int NK   = 21;
    localparam int TO   = 1000;
    localparam int HALF = 60;
    localparam int GAP  = 200;

    logic          clk = 1'b0;
    logic          rst;
    logic          PS2C, PS2D;
    logic [NK-1:0] key_state, key_press, key_release;
    logic          code_valid, code_break, code_ext, frame_err;
    logic [7:0]    code;

    always #5 clk = ~clk;

    ps2_keymap_decoder #(
        .CLK_DIV(4), .FILTER_LEN(8), .TIMEOUT_CYC(TO), .NUM_KEYS(NK),
        .KEYMAP(168'h3A31322A21221A3B33342B231B1C3C352C2D241D15)
    ) dut (
        .clk(clk), .rst(rst), .PS2C(PS2C), .PS2D(PS2D),
        .key_state(key_state), .key_press(key_press), .key_release(key_release),
        .code_valid(code_valid), .code(code), .code_break(code_break),
        .code_ext(code_ext), .frame_err(frame_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int press_cnt [NK] = '{default: 0};
    int rel_cnt   [NK] = '{default: 0};
    int cv_cnt = 0;
    int fe_cnt = 0;
    logic [7:0] last_code = 8'h00;
    logic       last_brk = 1'b0, last_ext = 1'b0;

    always @(negedge clk) begin
        if (code_valid) begin
            cv_cnt++;
            last_code = code;
            last_brk  = code_break;
            last_ext  = code_ext;
        end
        if (frame_err) fe_cnt++;
        for (int i = 0; i < NK; i++) begin
            if (key_press[i])   press_cnt[i]++;
            if (key_release[i]) rel_cnt[i]++;
        end
    end

    int ps [NK];
    int rs [NK];
    int cv0, fe0;

    task automatic snap();
        for (int i = 0; i < NK; i++) begin
            ps[i] = press_cnt[i];
            rs[i] = rel_cnt[i];
        end
        cv0 = cv_cnt;
        fe0 = fe_cnt;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        PS2D = b;
        repeat (HALF) @(negedge clk);
        PS2C = 1'b0;
        repeat (HALF) @(negedge clk);
        PS2C = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_bad,
                              input logic stop, input logic glitch);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
            if (glitch && i == 3) begin
                repeat (HALF) @(negedge clk);
                PS2C = 1'b0;
                repeat (20) @(negedge clk);
                PS2C = 1'b1;
            end
        end
        send_bit(~(^d) ^ par_bad);
        send_bit(stop);
        PS2D = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]    data;
        logic          par_bad;
        logic          stop;
        logic          glitch;
        logic          cv;
        logic [7:0]    code;
        logic          brk;
        logic          ext;
        logic          fe;
        logic [NK-1:0] st;
        logic [NK-1:0] pr;
        logic [NK-1:0] rl;
    } vec_t;

    vec_t va [19];
    vec_t vb [4];

    task automatic run_vec(input string tag, input vec_t v);
        logic [NK-1:0] pm, rm;
        int ptot, rtot;
        pm = '0; rm = '0; ptot = 0; rtot = 0;
        snap();
        send_frame(v.data, v.par_bad, v.stop, v.glitch);
        for (int i = 0; i < NK; i++) begin
            pm[i] = (press_cnt[i] != ps[i]);
            rm[i] = (rel_cnt[i] != rs[i]);
            ptot += press_cnt[i] - ps[i];
            rtot += rel_cnt[i] - rs[i];
        end
        chk({tag, " code_valid count"}, 32'(cv_cnt - cv0), {31'b0, v.cv});
        if (v.cv) begin
            chk({tag, " code"},       {24'b0, last_code}, {24'b0, v.code});
            chk({tag, " code_break"}, {31'b0, last_brk},  {31'b0, v.brk});
            chk({tag, " code_ext"},   {31'b0, last_ext},  {31'b0, v.ext});
        end
        chk({tag, " frame_err count"}, 32'(fe_cnt - fe0), {31'b0, v.fe});
        chk({tag, " key_state"},     32'(key_state), 32'(v.st));
        chk({tag, " key_press"},     32'(pm), 32'(v.pr));
        chk({tag, " key_release"},   32'(rm), 32'(v.rl));
        chk({tag, " press pulses"},  32'(ptot), 32'($countones(v.pr)));
        chk({tag, " release pulses"}, 32'(rtot), 32'($countones(v.rl)));
    endtask

    function automatic logic [31:0] all_outs();
        return 32'(|{key_state, key_press, key_release, code_valid, code,
                     code_break, code_ext, frame_err});
    endfunction

    initial begin
        int cyc;
        logic seen;

        //           data  pb stp gl  cv code   brk ext fe  state      press      release
        va[0]  = '{8'h1C, 0, 1, 0, 1, 8'h1C, 0, 0, 0, 21'h000080, 21'h000080, 21'h0};
        va[1]  = '{8'h1C, 0, 1, 0, 1, 8'h1C, 0, 0, 0, 21'h000080, 21'h0,      21'h0};
        va[2]  = '{8'hF0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 21'h000080, 21'h0,      21'h0};
        va[3]  = '{8'h1C, 0, 1, 0, 1, 8'h1C, 1, 0, 0, 21'h000000, 21'h0,      21'h000080};
        va[4]  = '{8'h15, 0, 1, 0, 1, 8'h15, 0, 0, 0, 21'h000001, 21'h000001, 21'h0};
        va[5]  = '{8'h3A, 0, 1, 0, 1, 8'h3A, 0, 0, 0, 21'h100001, 21'h100000, 21'h0};
        va[6]  = '{8'hF0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 21'h100001, 21'h0,      21'h0};
        va[7]  = '{8'h15, 0, 1, 0, 1, 8'h15, 1, 0, 0, 21'h100000, 21'h0,      21'h000001};
        va[8]  = '{8'hF0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 21'h100000, 21'h0,      21'h0};
        va[9]  = '{8'h3A, 0, 1, 0, 1, 8'h3A, 1, 0, 0, 21'h000000, 21'h0,      21'h100000};
        va[10] = '{8'hE0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 21'h000000, 21'h0,      21'h0};
        va[11] = '{8'h15, 0, 1, 0, 1, 8'h15, 0, 1, 0, 21'h000000, 21'h0,      21'h0};
        va[12] = '{8'h15, 1, 1, 0, 0, 8'h00, 0, 0, 1, 21'h000000, 21'h0,      21'h0};
        va[13] = '{8'h15, 0, 0, 0, 0, 8'h00, 0, 0, 1, 21'h000000, 21'h0,      21'h0};
        va[14] = '{8'hF0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 21'h000000, 21'h0,      21'h0};
        va[15] = '{8'h15, 1, 1, 0, 0, 8'h00, 0, 0, 1, 21'h000000, 21'h0,      21'h0};
        va[16] = '{8'h15, 0, 1, 0, 1, 8'h15, 0, 0, 0, 21'h000001, 21'h000001, 21'h0};
        va[17] = '{8'hF0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 21'h000001, 21'h0,      21'h0};
        va[18] = '{8'h15, 0, 1, 0, 1, 8'h15, 1, 0, 0, 21'h000000, 21'h0,      21'h000001};

        vb[0]  = '{8'h1D, 0, 1, 0, 1, 8'h1D, 0, 0, 0, 21'h000002, 21'h000002, 21'h0};
        vb[1]  = '{8'h15, 0, 1, 0, 1, 8'h15, 0, 0, 0, 21'h000003, 21'h000001, 21'h0};
        vb[2]  = '{8'h1B, 0, 1, 1, 1, 8'h1B, 0, 0, 0, 21'h000103, 21'h000100, 21'h0};
        vb[3]  = '{8'hFF, 0, 1, 0, 1, 8'hFF, 0, 0, 0, 21'h000000, 21'h0,      21'h000103};

        rst  = 1'b1;
        PS2C = 1'b1;
        PS2D = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset outputs", all_outs(), 32'h0);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        chk("idle after reset", all_outs(), 32'h0);

        for (int k = 0; k < 19; k++) run_vec($sformatf("va[%0d]", k), va[k]);

        // Frame stalls after start + 3 data bits.
        snap();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        PS2D = 1'b1;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 3 * TO) begin
            @(negedge clk);
            cyc++;
            if (fe_cnt != fe0) seen = 1'b1;
        end
        chk("timeout frame_err seen", {31'b0, seen}, 32'h1);
        chk("timeout delay window", {31'b0, (cyc >= TO - 150 && cyc <= TO + 150)}, 32'h1);
        repeat (GAP) @(negedge clk);
        chk("timeout frame_err count", 32'(fe_cnt - fe0), 32'h1);
        chk("timeout no code_valid", 32'(cv_cnt - cv0), 32'h0);

        for (int k = 0; k < 4; k++) run_vec($sformatf("vb[%0d]", k), vb[k]);

        // Reset during a partial frame while a key is held.
        run_vec("pre-reset 1C", va[0]);
        snap();
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        PS2D = 1'b1;
        rst  = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid-frame reset outputs", all_outs(), 32'h0);
        rst = 1'b0;
        repeat (GAP) @(negedge clk);
        chk("mid-frame reset no frame_err", 32'(fe_cnt - fe0), 32'h0);
        chk("mid-frame reset no code_valid", 32'(cv_cnt - cv0), 32'h0);
        chk("mid-frame reset key_state", 32'(key_state), 32'h0);
        run_vec("post-reset 1C", va[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
